// File: rtl/lut_cfg_pkg.sv
// Shared definitions for the split-LUT configuration loader.
//   cfg_w(inputs)          : config bits per cell (two cascaded LUT halves)
//   nbeats(inputs, data_w) : data beats per frame, checksum beat excluded
//   state_t                : loader FSM encoding
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  function automatic int cfg_w(input int inputs);
    return 2 * (1 << inputs);
  endfunction

  function automatic int nbeats(input int inputs, input int data_w);
    return cfg_w(inputs) / data_w;
  endfunction

endpackage

// File: rtl/lut_config_loader_shift_accum.sv
// Shadow assembly register, XOR accumulator and beat counter for one frame.
//   config_clk, config_rst : clock, async active-high reset
//   first                  : load the first beat of a frame (restarts everything)
//   shift                  : place the next beat below the previous ones
//   data                   : beat payload
//   shadow                 : config word being assembled, MSB-first
//   acc                    : running XOR of the data beats seen so far
//   count                  : data beats taken in this frame
module cfg_shift_accum
  import lut_cfg_pkg::*;
#(
  parameter int CFG_W  = cfg_w(4),
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic              config_clk,
  input  logic              config_rst,
  input  logic              first,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  output logic [CFG_W-1:0]  shadow,
  output logic [DATA_W-1:0] acc,
  output logic [CNT_W-1:0]  count
);

  // Beat aligned to the top slot; shifting it right by count slots lands it
  // directly below the beats already taken. The first beat overwrites the
  // whole register, so the OR in the shift path never sees stale bits.
  logic [CFG_W-1:0] beat_top;
  assign beat_top = CFG_W'(data) << (CFG_W - DATA_W);

  always_ff @(posedge config_clk or posedge config_rst) begin
    if (config_rst) begin
      shadow <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (first) begin
      shadow <= beat_top;
      acc    <= data;
      count  <= CNT_W'(1);
    end else if (shift) begin
      shadow <= shadow | (beat_top >> (int'(count) * DATA_W));
      acc    <= acc ^ data;
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lut_config_loader.sv
// Chunked bitstream loader for a split-LUT cell. Assembles a full config word
// in a shadow register, checks the frame XOR checksum and only then presents
// the word with a one-cycle load strobe, so the cell never sees a partial or
// corrupt word.
//   config_clk, config_rst : clock, async active-high reset
//   bs_valid/bs_ready      : beat handshake, accept on both high at a rising edge
//   bs_data, bs_last       : beat payload, checksum-beat marker
//   config_in, config_en   : config word to the cell, one-cycle load strobe
//   cfg_done, cfg_err      : sticky outcome of the last frame
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// SHIFT | taking data beats, then the checksum beat
// LOAD  | config_en high for one cycle, beats held off
// ERR   | frame too long; discarding beats until bs_last
module lut_config_loader
  import lut_cfg_pkg::*;
#(
  parameter int INPUTS   = 4,
  parameter int MEM_SIZE = 1 << INPUTS,
  parameter int DATA_W   = 8
) (
  input  logic                  config_clk,
  input  logic                  config_rst,
  input  logic                  bs_valid,
  output logic                  bs_ready,
  input  logic [DATA_W-1:0]     bs_data,
  input  logic                  bs_last,
  output logic [2*MEM_SIZE-1:0] config_in,
  output logic                  config_en,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  localparam int CFG_W  = cfg_w(INPUTS);
  localparam int NBEATS = nbeats(INPUTS, DATA_W);
  localparam int CNT_W  = $clog2(NBEATS + 1);

  generate
    if (CFG_W % DATA_W != 0) begin : g_bad_data_w
      $error("lut_config_loader: DATA_W must divide 2*MEM_SIZE");
    end
    if (MEM_SIZE != (1 << INPUTS)) begin : g_bad_mem_size
      $error("lut_config_loader: MEM_SIZE must equal 1<<INPUTS");
    end
  endgenerate

  state_t             state, state_next;
  logic [CFG_W-1:0]   shadow;
  logic [DATA_W-1:0]  acc;
  logic [CNT_W-1:0]   count;
  logic               accept, at_end;
  logic               first, shift, take, set_err, clr_flags, set_done;

  assign accept = bs_valid && bs_ready;
  assign at_end = (count == CNT_W'(NBEATS));

  cfg_shift_accum #(
    .CFG_W  (CFG_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shift_accum (
    .config_clk (config_clk),
    .config_rst (config_rst),
    .first      (first),
    .shift      (shift),
    .data       (bs_data),
    .shadow     (shadow),
    .acc        (acc),
    .count      (count)
  );

  always_comb begin
    state_next = state;
    first      = 1'b0;
    shift      = 1'b0;
    take       = 1'b0;
    set_err    = 1'b0;
    clr_flags  = 1'b0;
    set_done   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          clr_flags = 1'b1;
          first     = 1'b1;
          // a frame that ends on its first beat has no room for a checksum
          if (bs_last) set_err = 1'b1;
          else         state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          if (at_end) begin
            if (bs_last && (bs_data == acc)) begin
              take       = 1'b1;
              state_next = LOAD;
            end else if (bs_last) begin
              set_err    = 1'b1;
              state_next = IDLE;
            end else begin
              set_err    = 1'b1;
              state_next = ERR;
            end
          end else if (bs_last) begin
            set_err    = 1'b1;
            state_next = IDLE;
          end else begin
            shift = 1'b1;
          end
        end
      end
      LOAD: begin
        set_done   = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        if (accept && bs_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // bs_ready and config_en are registered from the next state, so they are
  // glitch-free and both low while reset is held.
  always_ff @(posedge config_clk or posedge config_rst) begin
    if (config_rst) begin
      state     <= IDLE;
      bs_ready  <= 1'b0;
      config_en <= 1'b0;
      config_in <= '0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_next;
      bs_ready  <= (state_next != LOAD);
      config_en <= (state_next == LOAD);
      if (take) config_in <= shadow;
      if (clr_flags)     cfg_done <= 1'b0;
      else if (set_done) cfg_done <= 1'b1;
      // a single-beat frame clears and re-flags in the same cycle
      if (set_err)        cfg_err <= 1'b1;
      else if (clr_flags) cfg_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_config_loader.sv
module tb_lut_config_loader;

  logic        clk = 1'b0;
  logic        config_rst;
  logic        bs_valid;
  logic        bs_ready;
  logic [7:0]  bs_data;
  logic        bs_last;
  logic [31:0] config_in;
  logic        config_en;
  logic        cfg_done;
  logic        cfg_err;

  lut_config_loader #(.INPUTS(4), .MEM_SIZE(16), .DATA_W(8)) dut (
    .config_clk (clk),
    .config_rst (config_rst),
    .bs_valid   (bs_valid),
    .bs_ready   (bs_ready),
    .bs_data    (bs_data),
    .bs_last    (bs_last),
    .config_in  (config_in),
    .config_en  (config_en),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;     // beats in frame; the last one carries bs_last
    logic [63:0] d;     // beats, first beat in the top byte
    logic        ok;    // frame should load
    logic [31:0] word;  // word it should load
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] sb_q [$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_loads = 0;
  logic        en_prev = 1'b0;
  logic [31:0] exp_cfg = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // scoreboard consumer: every load strobe must match the oldest expected word
  always @(negedge clk) begin
    if (!config_rst && config_en) begin
      n_loads++;
      chk("en_width", 32'(en_prev), 32'd0);
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_load: got strobe with %h, required no load", config_in);
      end else begin
        chk("sb_load_word", config_in, sb_q.pop_front());
      end
    end
    en_prev = config_en && !config_rst;
  end

  task automatic send_beat(input logic [7:0] d, input logic l, input bit bub);
    int guard;
    if (bub) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bs_valid = 1'b0;
        bs_data  = 8'($urandom);
        bs_last  = 1'($urandom);
      end
    end
    @(negedge clk);
    bs_valid = 1'b1;
    bs_data  = d;
    bs_last  = l;
    guard = 0;
    while (!bs_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout: got bs_ready=0 for 20 cycles, required 1");
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v, input bit bub);
    int l0;
    l0 = n_loads;
    if (v.ok) sb_q.push_back(v.word);
    for (int i = 0; i < v.n; i++)
      send_beat(v.d[63-8*i -: 8], (i == v.n - 1), bub);
    @(negedge clk);
    bs_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (v.ok) exp_cfg = v.word;
    chk($sformatf("v%0d_config_in", idx), config_in, exp_cfg);
    chk($sformatf("v%0d_done", idx), 32'(cfg_done), 32'(v.ok));
    chk($sformatf("v%0d_err", idx), 32'(cfg_err), 32'(!v.ok));
    chk($sformatf("v%0d_loads", idx), 32'(n_loads - l0), 32'(v.ok));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_config_in"}, config_in, 32'd0);
    chk({tag, "_en"}, 32'(config_en), 32'd0);
    chk({tag, "_done"}, 32'(cfg_done), 32'd0);
    chk({tag, "_err"}, 32'(cfg_err), 32'd0);
    chk({tag, "_ready"}, 32'(bs_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    vecs[0] = '{5, 64'hDEADBEEF22000000, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{5, 64'hDEADBEEF23000000, 1'b0, 32'h0};
    vecs[2] = '{3, 64'h1122330000000000, 1'b0, 32'h0};
    vecs[3] = '{6, 64'h1122334455660000, 1'b0, 32'h0};
    vecs[4] = '{5, 64'h0102030404000000, 1'b1, 32'h01020304};
    vecs[5] = '{5, 64'h1234567808000000, 1'b1, 32'h12345678};
    vecs[6] = '{1, 64'hAA00000000000000, 1'b0, 32'h0};
    vecs[7] = '{5, 64'h0000000000000000, 1'b1, 32'h00000000};
    vecs[8] = '{5, 64'hFF00FF0000000000, 1'b1, 32'hFF00FF00};

    config_rst = 1'b1;
    bs_valid   = 1'b0;
    bs_data    = 8'h00;
    bs_last    = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    config_rst = 1'b0;

    for (int pass = 0; pass < 2; pass++)
      for (int i = 0; i < 9; i++)
        run_vec(pass * 10 + i, vecs[i], pass == 1);

    // next frame's first beat held on bs_valid through the strobe cycle
    sb_q.push_back(32'hDEADBEEF);
    sb_q.push_back(32'h01020304);
    send_beat(8'hDE, 1'b0, 1'b0);
    send_beat(8'hAD, 1'b0, 1'b0);
    send_beat(8'hBE, 1'b0, 1'b0);
    send_beat(8'hEF, 1'b0, 1'b0);
    send_beat(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    bs_valid = 1'b1;
    bs_data  = 8'h01;
    bs_last  = 1'b0;
    chk("bp_load_en", 32'(config_en), 32'd1);
    chk("bp_load_ready", 32'(bs_ready), 32'd0);
    chk("bp_load_word", config_in, 32'hDEADBEEF);
    chk("bp_load_done", 32'(cfg_done), 32'd0);
    @(negedge clk);
    chk("bp_post_en", 32'(config_en), 32'd0);
    chk("bp_post_ready", 32'(bs_ready), 32'd1);
    chk("bp_post_done", 32'(cfg_done), 32'd1);
    send_beat(8'h02, 1'b0, 1'b0);
    send_beat(8'h03, 1'b0, 1'b0);
    send_beat(8'h04, 1'b0, 1'b0);
    send_beat(8'h04, 1'b1, 1'b0);
    @(negedge clk);
    bs_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_cfg = 32'h01020304;
    chk("bp_second_word", config_in, exp_cfg);
    chk("bp_second_done", 32'(cfg_done), 32'd1);
    chk("bp_second_err", 32'(cfg_err), 32'd0);

    // async reset between edges after two beats of a frame
    send_beat(8'hAA, 1'b0, 1'b0);
    send_beat(8'hBB, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    config_rst = 1'b1;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    bs_valid   = 1'b0;
    config_rst = 1'b0;
    exp_cfg    = '0;
    run_vec(30, vecs[4], 1'b0);

    // async reset during the strobe cycle: strobe dropped, word cleared
    l0 = n_loads;
    send_beat(8'hDE, 1'b0, 1'b0);
    send_beat(8'hAD, 1'b0, 1'b0);
    send_beat(8'hBE, 1'b0, 1'b0);
    send_beat(8'hEF, 1'b0, 1'b0);
    send_beat(8'h22, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_load_en_before", 32'(config_en), 32'd1);
    config_rst = 1'b1;
    #1;
    check_zero("rst_load");
    @(negedge clk);
    bs_valid   = 1'b0;
    config_rst = 1'b0;
    exp_cfg    = '0;
    repeat (2) @(negedge clk);
    chk("rst_load_no_strobe", 32'(n_loads - l0), 32'd0);
    run_vec(31, vecs[4], 1'b0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
